// File: rtl/ofdm_pkg.sv
// -----------------------------------------------------------------------------
// ofdm_pkg -- shared constants and types for the OFDM symbol demapper.
//
// Contents:
//   MODE_QPSK / MODE_QAM16   encoding of the constellation select input
//   QPSK_Q1..QPSK_Q4         two-bit QPSK codes for the four quadrants
//   NBITS_QPSK / NBITS_QAM16 number of valid decided bits per mode
//   demap_entry_t            one output-buffer entry {last, nbits, bits}
// -----------------------------------------------------------------------------
package ofdm_pkg;

  // Constellation select
  localparam logic MODE_QPSK  = 1'b0;
  localparam logic MODE_QAM16 = 1'b1;

  // QPSK quadrant codes (zero counts as non-positive on either axis)
  localparam logic [1:0] QPSK_Q1 = 2'b00;  // I > 0,  Q > 0
  localparam logic [1:0] QPSK_Q2 = 2'b01;  // I <= 0, Q > 0
  localparam logic [1:0] QPSK_Q3 = 2'b10;  // I <= 0, Q <= 0
  localparam logic [1:0] QPSK_Q4 = 2'b11;  // I > 0,  Q <= 0

  // Valid bit counts reported alongside each decision
  localparam logic [2:0] NBITS_QPSK  = 3'd2;
  localparam logic [2:0] NBITS_QAM16 = 3'd4;

  // Output buffer entry; field order gives the packed layout {last, nbits, bits}
  typedef struct packed {
    logic       last;
    logic [2:0] nbits;
    logic [3:0] bits;
  } demap_entry_t;

  localparam int ENTRY_W = $bits(demap_entry_t);

endpackage

// File: rtl/demap_fifo.sv
// -----------------------------------------------------------------------------
// demap_fifo -- synchronous FIFO with a registered head-of-queue output.
//
// rdata always holds the oldest stored entry (all zeros when empty), so a
// write into an empty FIFO is visible on rdata the cycle after the write.
// A read is honoured only while the FIFO is non-empty. A write into a full
// FIFO is accepted only when a read happens in the same cycle; otherwise it
// is ignored and the caller is expected to flag the drop.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   wr     in   write request
//   wdata  in   WIDTH-bit entry to store
//   rd     in   read request (pops the head when non-empty)
//   rdata  out  registered head entry, zero when empty
//   full   out  DEPTH entries stored
//   empty  out  no entries stored (registered)
// -----------------------------------------------------------------------------
module demap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count;
  logic [AW:0]      remain;
  logic [AW:0]      count_nxt;
  logic             do_rd;
  logic             do_wr;
  logic [WIDTH-1:0] head_nxt;

  always_comb begin
    full       = (count == FULL_COUNT);
    do_rd      = rd && !empty;
    do_wr      = wr && (!full || do_rd);
    rd_ptr_nxt = do_rd ? rd_ptr + AW'(1) : rd_ptr;
    // Entries left after this cycle's read, before this cycle's write
    remain     = do_rd ? count - (AW+1)'(1) : count;
    count_nxt  = do_wr ? remain + (AW+1)'(1) : remain;

    // Next head: nothing left, the entry being written now, or a stored one
    if (count_nxt == '0) begin
      head_nxt = '0;
    end else if (remain == '0) begin
      head_nxt = wdata;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the clock edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      rdata  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      empty  <= (count_nxt == '0);
      rdata  <= head_nxt;
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and leaving it unreset lets it map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/qam_demap.sv
// -----------------------------------------------------------------------------
// qam_demap -- hard-decision QPSK / 16-QAM demapper for OFDM frames.
//
// Each valid I/Q sample from the FFT is decided in one registered stage and
// pushed into an output FIFO. A symbol counter tags the last sample of every
// frame and latches the constellation mode at each frame start; mid-frame
// mode changes are ignored. With the FIFO full and no read, the decided
// symbol is dropped and a sticky overflow flag is raised.
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   inx, iny    in   signed I / Q sample, DATA_W bits
//   fft_en      in   sample valid (no backpressure toward the FFT)
//   mode        in   0 = QPSK, 1 = 16-QAM (sampled at frame start)
//   thr         in   16-QAM inner/outer magnitude threshold, unsigned
//   en          out  output entry valid
//   out         out  decided bits (QPSK in out[1:0], 16-QAM {sI,mI,sQ,mQ})
//   out_nbits   out  number of valid bits in out (2 or 4)
//   out_last    out  entry is the last symbol of its frame
//   out_ready   in   downstream accepts the entry when en is high
//   overflow    out  sticky: a decided symbol was dropped
//   frame_mode  out  mode in force for the current frame
// -----------------------------------------------------------------------------
module qam_demap
  import ofdm_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int SYM_PER_FRAME = 64,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] inx,
  input  logic signed [DATA_W-1:0] iny,
  input  logic                     fft_en,
  input  logic                     mode,
  input  logic        [DATA_W-2:0] thr,
  output logic                     en,
  output logic        [3:0]        out,
  output logic        [2:0]        out_nbits,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic                     frame_mode
);

  localparam int                 CNT_W    = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0]   LAST_SYM = CNT_W'(SYM_PER_FRAME - 1);

  // |x| saturated so the most negative code maps to the largest positive one;
  // the result therefore always fits in DATA_W-1 bits.
  function automatic logic [DATA_W-2:0] sat_abs(input logic signed [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
      return {(DATA_W-1){1'b1}};
    end
    return x[DATA_W-1] ? (DATA_W-1)'(-x) : x[DATA_W-2:0];
  endfunction

  logic [CNT_W-1:0] sym_cnt;
  logic             applied_mode;
  logic             pos_i;
  logic             pos_q;
  logic             mag_i;
  logic             mag_q;
  demap_entry_t     dec_next;
  demap_entry_t     dec_entry;
  logic             dec_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  demap_entry_t     head;

  // ---------------------------------------------------------------------------
  // Decision logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default at the top of the block,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    dec_next       = '0;
    dec_next.nbits = NBITS_QPSK;

    // The first sample of a frame uses the incoming mode directly, since
    // frame_mode is only updated by that same sample.
    applied_mode = (sym_cnt == '0) ? mode : frame_mode;

    pos_i = !inx[DATA_W-1] && (inx != '0);
    pos_q = !iny[DATA_W-1] && (iny != '0);
    mag_i = sat_abs(inx) > thr;
    mag_q = sat_abs(iny) > thr;

    dec_next.last = (sym_cnt == LAST_SYM);

    if (applied_mode == MODE_QAM16) begin
      dec_next.nbits = NBITS_QAM16;
      dec_next.bits  = {!pos_i, mag_i, !pos_q, mag_q};
    end else begin
      case ({pos_i, pos_q})
        2'b11:   dec_next.bits = {2'b00, QPSK_Q1};
        2'b01:   dec_next.bits = {2'b00, QPSK_Q2};
        2'b00:   dec_next.bits = {2'b00, QPSK_Q3};
        default: dec_next.bits = {2'b00, QPSK_Q4};
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decision register, symbol counter, frame mode, overflow
  // ---------------------------------------------------------------------------
  // A write is lost only when the FIFO is full and nothing leaves this cycle.
  assign drop = dec_valid && fifo_full && !(en && out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_cnt    <= '0;
      dec_valid  <= 1'b0;
      dec_entry  <= '0;
      frame_mode <= MODE_QPSK;
      overflow   <= 1'b0;
    end else begin
      dec_valid <= fft_en;
      if (fft_en) begin
        dec_entry <= dec_next;
        sym_cnt   <= (sym_cnt == LAST_SYM) ? '0 : sym_cnt + CNT_W'(1);
        if (sym_cnt == '0) begin
          frame_mode <= mode;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  demap_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (dec_valid),
    .wdata (dec_entry),
    .rd    (out_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The FIFO head register reads as zero when empty, so the fields need no
  // extra gating here.
  assign en        = !fifo_empty;
  assign out       = head.bits;
  assign out_nbits = head.nbits;
  assign out_last  = head.last;

endmodule

// File: tb/tb_qam_demap.sv
// -----------------------------------------------------------------------------
// tb_qam_demap -- self-checking bench for qam_demap.
//
// A queue-based reference model (decision arithmetic on plain integers, the
// output buffer as a bounded queue) is compared with the DUT on every falling
// edge. Directed sections pin hand-computed values for QPSK quadrants, 16-QAM
// levels, frame/mode tagging, overflow, full read+write and reset mid-frame,
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_qam_demap;

  localparam int DW    = 16;
  localparam int SYM   = 4;
  localparam int DEPTH = 8;

  logic                 clk;
  logic                 reset;
  logic signed [DW-1:0] inx;
  logic signed [DW-1:0] iny;
  logic                 fft_en;
  logic                 mode;
  logic        [DW-2:0] thr;
  logic                 en;
  logic        [3:0]    out;
  logic        [2:0]    out_nbits;
  logic                 out_last;
  logic                 out_ready;
  logic                 overflow;
  logic                 frame_mode;

  qam_demap #(
    .DATA_W        (DW),
    .SYM_PER_FRAME (SYM),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inx        (inx),
    .iny        (iny),
    .fft_en     (fft_en),
    .mode       (mode),
    .thr        (thr),
    .en         (en),
    .out        (out),
    .out_nbits  (out_nbits),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .frame_mode (frame_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] model_bits(input int x, input int y, input bit m, input int t);
    int ax, ay;
    if (!m) begin
      if (x > 0 && y > 0)        return 4'd0;
      else if (x <= 0 && y > 0)  return 4'd1;
      else if (x <= 0 && y <= 0) return 4'd2;
      else                       return 4'd3;
    end
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    if (ax > 32767) ax = 32767;
    if (ay > 32767) ay = 32767;
    return {x <= 0, ax > t, y <= 0, ay > t};
  endfunction

  logic [7:0] q[$];       // buffered entries {last, nbits, bits}
  bit         live = 0;
  bit         pend_v;
  logic [7:0] pend;
  int         m_cnt;
  bit         m_fm;
  bit         m_ovf;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      pend_v = 0;
      m_cnt  = 0;
      m_fm   = 0;
      m_ovf  = 0;
      live   = 1;
    end else if (live) begin
      bit rd;
      bit use_mode;
      rd = (q.size() != 0) && out_ready;
      if (rd) q.delete(0);
      if (pend_v) begin
        if (q.size() < DEPTH) q.push_back(pend);
        else m_ovf = 1;
      end
      pend_v = fft_en;
      if (fft_en) begin
        use_mode = (m_cnt == 0) ? mode : m_fm;
        if (m_cnt == 0) m_fm = mode;
        pend = {m_cnt == SYM - 1, use_mode ? 3'd4 : 3'd2,
                model_bits(int'(inx), int'(iny), use_mode, int'(thr))};
        m_cnt = (m_cnt + 1) % SYM;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      logic [7:0] exp_e;
      exp_e = (q.size() != 0) ? q[0] : 8'h00;
      check("cyc_en", en, q.size() != 0);
      check("cyc_entry", {out_last, out_nbits, out}, exp_e);
      check("cyc_overflow", overflow, m_ovf);
      check("cyc_frame_mode", frame_mode, m_fm);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int x, input int y);
    inx    = DW'(x);
    iny    = DW'(y);
    fft_en = 1'b1;
  endtask

  task automatic reset_dut();
    fft_en = 1'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
  endtask

  function automatic int pick(input int t);
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return -32768;
      2:       return 32767;
      3:       return t;
      4:       return -t;
      5:       return t + 1;
      6:       return -(t + 1);
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  int         qx[5];
  int         qy[5];
  logic [3:0] qexp[5];
  int         ax[4];
  int         ay[4];
  logic [3:0] aexp[4];
  int         nout;

  initial begin
    reset     = 1'b1;
    inx       = '0;
    iny       = '0;
    fft_en    = 1'b0;
    mode      = 1'b0;
    thr       = 15'd200;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_en", en, 0);
    check("rst_out", out, 0);
    check("rst_nbits", out_nbits, 0);
    check("rst_last", out_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_mode", frame_mode, 0);
    reset = 1'b0;

    // QPSK quadrants, each output two cycles after its input
    qx   = '{100, -100, -100, 100, 0};
    qy   = '{100, 100, -100, -100, 0};
    qexp = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      put(qx[i], qy[i]);
      tick();
      fft_en = 1'b0;
      check("qpsk_early_en", en, 0);
      tick();
      check("qpsk_en", en, 1);
      check("qpsk_out", out, qexp[i]);
      check("qpsk_nbits", out_nbits, 2);
    end
    tick();

    // 16-QAM levels, threshold 200 (|x| == thr counts as inner)
    reset_dut();
    mode = 1'b1;
    thr  = 15'd200;
    ax   = '{300, -100, -32768, 200};
    ay   = '{-100, 300, 0, -201};
    aexp = '{4'b0110, 4'b1001, 4'b1110, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      put(ax[i], ay[i]);
      tick();
      fft_en = 1'b0;
      tick();
      check("qam_en", en, 1);
      check("qam_out", out, aexp[i]);
      check("qam_nbits", out_nbits, 4);
    end
    tick();

    // Frame tagging and mode latching, mode toggled at symbol 2
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mode = (i >= 2);
      put(40 + 10 * i, -30 - 10 * i);
      tick();
      check("frame_mode_latch", frame_mode, (i >= 4));
      if (i >= 1) begin
        check("frame_en", en, 1);
        check("frame_last", out_last, ((i - 1) % SYM) == SYM - 1);
        check("frame_nbits", out_nbits, (i - 1) >= 4 ? 4 : 2);
      end
    end
    fft_en = 1'b0;
    tick();
    check("frame_last_sym7", out_last, 1);
    check("frame_nbits_sym7", out_nbits, 4);
    tick();

    // Full FIFO with simultaneous read and write: no drop
    reset_dut();
    mode      = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put(pick(200), pick(200));
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      put(pick(200), pick(200));
      tick();
    end
    fft_en = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("fullrw_overflow", overflow, 0);

    // Backpressure and overflow: 10 inputs into 8 entries
    reset_dut();
    mode      = 1'b1;
    out_ready = 1'b0;
    put(300, -100);
    tick();
    for (int i = 1; i < 10; i++) begin
      put(pick(200), pick(200));
      tick();
    end
    fft_en = 1'b0;
    tick();
    tick();
    check("ovf_set", overflow, 1);
    check("ovf_stall_en", en, 1);
    tick();
    tick();
    check("ovf_stall_head", {out_last, out_nbits, out}, 8'b0_100_0110);
    out_ready = 1'b1;
    nout = 0;
    for (int i = 0; i < 20; i++) begin
      if (en) nout++;
      tick();
    end
    check("ovf_drained", nout, 8);
    check("ovf_sticky", overflow, 1);

    // Reset mid-frame with three entries buffered
    reset_dut();
    mode      = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(100, 100);
      tick();
    end
    fft_en = 1'b0;
    tick();
    check("midrst_buffered", en, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_en", en, 0);
    check("midrst_overflow", overflow, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(-100, 100);
      tick();
      fft_en = 1'b0;
      tick();
      check("midrst_out_en", en, 1);
      check("midrst_last", out_last, i == 3);
    end
    tick();

    // Randomized run, checked every cycle against the model
    reset_dut();
    for (int c = 0; c < 4000; c++) begin
      int t;
      if ($urandom_range(0, 49) == 0) thr = DW'($urandom_range(0, 32767)) & 15'h7fff;
      t = int'(thr);
      mode = $urandom_range(0, 1);
      put(pick(t), pick(t));
      fft_en = ($urandom_range(0, 3) != 0);
      // alternate phases of free flow and heavy backpressure
      out_ready = ((c / 300) % 2 == 0) ? ($urandom_range(0, 5) != 0)
                                       : ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset  = 1'b0;
    fft_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
